// File: rtl/serdesphy_clk_pkg.sv
// ---------------------------------------------------------------------------
// serdesphy_clk_pkg : shared qualifier state encoding and lock-sequencer constants
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serdesphy_clk_pkg;

  typedef logic [1:0] lock_state_t;

  localparam lock_state_t ST_OFF    = 2'd0;
  localparam lock_state_t ST_WAIT   = 2'd1;
  localparam lock_state_t ST_LOCKED = 2'd2;

  localparam int DEF_PLL_LOCK_CYCLES = 240;
  localparam int DEF_CDR_LOCK_CYCLES = 100;
  localparam int LOL_CNT_W           = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serdesphy_lock_qualifier.sv
// ---------------------------------------------------------------------------
// serdesphy_lock_qualifier : 2-flop synchroniser plus consecutive-sample lock FSM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serdesphy_lock_qualifier
  import serdesphy_clk_pkg::*;
#(
  parameter int N     = DEF_PLL_LOCK_CYCLES,
  parameter int CNT_W = 12
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic lock_raw_i,
  output logic lock_o,
  output logic lol_o
);

  localparam logic [CNT_W-1:0] N_C = CNT_W'(N);

  logic             sync1_q;
  logic             sync2_q;
  lock_state_t      state_q;
  lock_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lol_o   = 1'b0;
    if (!en_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOCKED: begin
          if (!sync2_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            lol_o   = 1'b1;
          end
        end
        // OFF counts its first enabled sample too, so OFF and WAIT share this path
        default: begin
          if (!sync2_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_inc == N_C) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= lock_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lock_o = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: rtl/serdesphy_lock_sequencer.sv
// ---------------------------------------------------------------------------
// serdesphy_lock_sequencer : PLL/CDR lock qualification and clock-enable sequencing
// Optional LOL event counter: define SERDESPHY_LOL_COUNT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serdesphy_lock_sequencer
  import serdesphy_clk_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int CNT_W           = 12,
  parameter int PLL_LOCK_CYCLES = DEF_PLL_LOCK_CYCLES,
  parameter int CDR_LOCK_CYCLES = DEF_CDR_LOCK_CYCLES
) (
  input  logic                 clk_ref_24m,
  input  logic                 rst_n,
  input  logic                 phy_en,
  input  logic                 pll_rst,
  input  logic [NUM_LANES-1:0] cdr_rst,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic                 pll_lock_raw,
  input  logic [NUM_LANES-1:0] cdr_lock_raw,
  input  logic                 lol_clr,
  output logic                 clk_24m_en,
  output logic                 clk_240m_tx_en,
  output logic [NUM_LANES-1:0] clk_240m_rx_en,
  output logic                 pll_lock,
  output logic [NUM_LANES-1:0] cdr_lock,
  output logic                 phy_ready,
  output logic [LOL_CNT_W-1:0] pll_lol_cnt
);

  localparam int MAX_CYC = max_int(PLL_LOCK_CYCLES, CDR_LOCK_CYCLES);

  generate
    if (NUM_LANES < 1 || $clog2(MAX_CYC + 1) > CNT_W) begin : g_cnt_w_check
      $error("serdesphy_lock_sequencer: CNT_W too narrow for lock cycle count or NUM_LANES < 1");
    end
  endgenerate

  logic                 pll_en;
  logic                 pll_lol;
  logic [NUM_LANES-1:0] cdr_en;
  logic [NUM_LANES-1:0] cdr_lol_unused;
  logic                 lanes_ok;

  logic                 clk_24m_en_q;
  logic                 tx_en_q;
  logic [NUM_LANES-1:0] rx_en_q;
  logic                 phy_ready_q;
  logic                 phy_ready_d;

  assign pll_en = phy_en & ~pll_rst;

  serdesphy_lock_qualifier #(
    .N     (PLL_LOCK_CYCLES),
    .CNT_W (CNT_W)
  ) u_pll_qual (
    .clk_i      (clk_ref_24m),
    .rst_ni     (rst_n),
    .en_i       (pll_en),
    .lock_raw_i (pll_lock_raw),
    .lock_o     (pll_lock),
    .lol_o      (pll_lol)
  );

  // Lanes are gated by the qualified PLL, so a PLL loss of lock drops every lane next edge
  assign cdr_en = {NUM_LANES{phy_en & pll_lock}} & lane_en & ~cdr_rst;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      serdesphy_lock_qualifier #(
        .N     (CDR_LOCK_CYCLES),
        .CNT_W (CNT_W)
      ) u_cdr_qual (
        .clk_i      (clk_ref_24m),
        .rst_ni     (rst_n),
        .en_i       (cdr_en[i]),
        .lock_raw_i (cdr_lock_raw[i]),
        .lock_o     (cdr_lock[i]),
        .lol_o      (cdr_lol_unused[i])
      );
    end
  endgenerate

  assign lanes_ok    = &(~lane_en | cdr_lock);
  assign phy_ready_d = phy_en & pll_lock & (|lane_en) & lanes_ok;

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      clk_24m_en_q <= 1'b0;
      tx_en_q      <= 1'b0;
      rx_en_q      <= '0;
      phy_ready_q  <= 1'b0;
    end else begin
      clk_24m_en_q <= phy_en;
      tx_en_q      <= pll_lock;
      rx_en_q      <= cdr_lock;
      phy_ready_q  <= phy_ready_d;
    end
  end

  assign clk_24m_en     = clk_24m_en_q;
  assign clk_240m_tx_en = tx_en_q;
  assign clk_240m_rx_en = rx_en_q;
  assign phy_ready      = phy_ready_q;

`ifdef SERDESPHY_LOL_COUNT_EN
  logic [LOL_CNT_W-1:0] lol_cnt_q;
  logic [LOL_CNT_W-1:0] lol_cnt_d;

  // A clear coinciding with an event still records that event
  always_comb begin
    lol_cnt_d = lol_cnt_q;
    if (lol_clr) begin
      lol_cnt_d = {{(LOL_CNT_W-1){1'b0}}, pll_lol};
    end else if (pll_lol && (lol_cnt_q != {LOL_CNT_W{1'b1}})) begin
      lol_cnt_d = lol_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      lol_cnt_q <= '0;
    end else begin
      lol_cnt_q <= lol_cnt_d;
    end
  end

  assign pll_lol_cnt = lol_cnt_q;
`else
  logic lol_unused;
  assign lol_unused  = lol_clr ^ pll_lol;
  assign pll_lol_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serdesphy_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serdesphy_lock_sequencer : run-length reference model plus directed lock scenarios
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serdesphy_lock_sequencer;

  localparam int NL     = 4;
  localparam int PLL_N  = 240;
  localparam int CDR_N  = 100;
  localparam int RUNCAP = 1000000;

  logic          clk;
  logic          rst_n;
  logic          phy_en, pll_rst, pll_lock_raw, lol_clr;
  logic [NL-1:0] cdr_rst, lane_en, cdr_lock_raw;
  logic          clk_24m_en, clk_240m_tx_en, pll_lock, phy_ready;
  logic [NL-1:0] clk_240m_rx_en, cdr_lock;
  logic [7:0]    pll_lol_cnt;

  logic          f_phy_en, f_pll_rst, f_pll_raw, f_lol_clr;
  logic [0:0]    f_cdr_rst, f_lane_en, f_cdr_raw;
  logic          f_clk24, f_tx, f_pll_lock, f_ready;
  logic [0:0]    f_rx, f_cdr_lock;
  logic [7:0]    f_lol_cnt;

  int vectors     = 0;
  int miscompares = 0;

  serdesphy_lock_sequencer u_dut (
    .clk_ref_24m    (clk),
    .rst_n          (rst_n),
    .phy_en         (phy_en),
    .pll_rst        (pll_rst),
    .cdr_rst        (cdr_rst),
    .lane_en        (lane_en),
    .pll_lock_raw   (pll_lock_raw),
    .cdr_lock_raw   (cdr_lock_raw),
    .lol_clr        (lol_clr),
    .clk_24m_en     (clk_24m_en),
    .clk_240m_tx_en (clk_240m_tx_en),
    .clk_240m_rx_en (clk_240m_rx_en),
    .pll_lock       (pll_lock),
    .cdr_lock       (cdr_lock),
    .phy_ready      (phy_ready),
    .pll_lol_cnt    (pll_lol_cnt)
  );

  // Short-count instance so hundreds of loss-of-lock events stay cheap
  serdesphy_lock_sequencer #(
    .NUM_LANES       (1),
    .CNT_W           (4),
    .PLL_LOCK_CYCLES (3),
    .CDR_LOCK_CYCLES (2)
  ) u_fast (
    .clk_ref_24m    (clk),
    .rst_n          (rst_n),
    .phy_en         (f_phy_en),
    .pll_rst        (f_pll_rst),
    .cdr_rst        (f_cdr_rst),
    .lane_en        (f_lane_en),
    .pll_lock_raw   (f_pll_raw),
    .cdr_lock_raw   (f_cdr_raw),
    .lol_clr        (f_lol_clr),
    .clk_24m_en     (f_clk24),
    .clk_240m_tx_en (f_tx),
    .clk_240m_rx_en (f_rx),
    .pll_lock       (f_pll_lock),
    .cdr_lock       (f_cdr_lock),
    .phy_ready      (f_ready),
    .pll_lol_cnt    (f_lol_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a qualifier is locked exactly when its run of consecutive
  // edges with (enable & synchronised lock) has reached its cycle count.
  int            m_pll_run;
  int            m_cdr_run [NL];
  logic          m_ps1, m_ps2;
  logic [NL-1:0] m_cs1, m_cs2;
  logic          m_clk24, m_tx, m_ready;
  logic [NL-1:0] m_rx;
  logic [7:0]    m_lol;
  logic          m_pll_lock;
  logic [NL-1:0] m_cdr_lock;
  logic          m_lol_ev;

  always_comb begin
    m_pll_lock = (m_pll_run >= PLL_N);
    for (int i = 0; i < NL; i++) m_cdr_lock[i] = (m_cdr_run[i] >= CDR_N);
    m_lol_ev = m_pll_lock && phy_en && !pll_rst && !m_ps2;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pll_run <= 0;
      for (int i = 0; i < NL; i++) m_cdr_run[i] <= 0;
      m_ps1 <= 1'b0; m_ps2 <= 1'b0; m_cs1 <= '0; m_cs2 <= '0;
      m_clk24 <= 1'b0; m_tx <= 1'b0; m_ready <= 1'b0; m_rx <= '0; m_lol <= 8'd0;
    end else begin
      m_ps1 <= pll_lock_raw; m_ps2 <= m_ps1;
      m_cs1 <= cdr_lock_raw; m_cs2 <= m_cs1;
      m_pll_run <= (phy_en && !pll_rst && m_ps2) ? ((m_pll_run < RUNCAP) ? m_pll_run + 1 : m_pll_run) : 0;
      for (int i = 0; i < NL; i++)
        m_cdr_run[i] <= (phy_en && lane_en[i] && !cdr_rst[i] && m_pll_lock && m_cs2[i]) ?
                        ((m_cdr_run[i] < RUNCAP) ? m_cdr_run[i] + 1 : m_cdr_run[i]) : 0;
      m_clk24 <= phy_en;
      m_tx    <= m_pll_lock;
      m_rx    <= m_cdr_lock;
      m_ready <= phy_en && m_pll_lock && (lane_en != '0) && ((lane_en & ~m_cdr_lock) == '0);
`ifdef SERDESPHY_LOL_COUNT_EN
      if (lol_clr) m_lol <= m_lol_ev ? 8'd1 : 8'd0;
      else if (m_lol_ev && m_lol != 8'd255) m_lol <= m_lol + 8'd1;
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if ({clk_24m_en, clk_240m_tx_en, clk_240m_rx_en, pll_lock, cdr_lock, phy_ready, pll_lol_cnt} !==
          {m_clk24, m_tx, m_rx, m_pll_lock, m_cdr_lock, m_ready, m_lol}) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time,
                 {clk_24m_en, clk_240m_tx_en, clk_240m_rx_en, pll_lock, cdr_lock, phy_ready, pll_lol_cnt},
                 {m_clk24, m_tx, m_rx, m_pll_lock, m_cdr_lock, m_ready, m_lol});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    phy_en = 0; pll_rst = 0; pll_lock_raw = 0; lol_clr = 0;
    cdr_rst = '0; lane_en = '0; cdr_lock_raw = '0;
    f_phy_en = 0; f_pll_rst = 0; f_pll_raw = 0; f_lol_clr = 0;
    f_cdr_rst = '0; f_lane_en = '0; f_cdr_raw = '0;
    adv(3);
    chk("reset_outputs", {clk_24m_en, clk_240m_tx_en, clk_240m_rx_en, pll_lock, cdr_lock, phy_ready, pll_lol_cnt}, 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] lol_exp(input int n);
`ifdef SERDESPHY_LOL_COUNT_EN
    return (n > 255) ? 8'd255 : n[7:0];
`else
    return (n > 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  initial begin
    do_reset();

    // Bring-up with every raw lock high from the moment phy_en rises
    phy_en = 1; lane_en = 4'hF; pll_lock_raw = 1; cdr_lock_raw = 4'hF;
    adv(241); chk("bringup_pll_241", pll_lock, 0);
    adv(1);   chk("bringup_pll_242", pll_lock, 1); chk("bringup_tx_242", clk_240m_tx_en, 0);
    adv(1);   chk("bringup_tx_243", clk_240m_tx_en, 1);
    adv(98);  chk("bringup_cdr_341", cdr_lock, 4'h0);
    adv(1);   chk("bringup_cdr_342", cdr_lock, 4'hF); chk("bringup_rdy_342", phy_ready, 0);
    adv(1);   chk("bringup_rdy_343", phy_ready, 1); chk("bringup_rx_343", clk_240m_rx_en, 4'hF);

    // PLL raw lock lost for 3 samples
    pll_lock_raw = 0;
    adv(2);   chk("lol_pll_k1", pll_lock, 1);
    adv(1);   chk("lol_pll_k2", pll_lock, 0); chk("lol_cnt_k2", pll_lol_cnt, lol_exp(1));
    pll_lock_raw = 1;
    adv(1);   chk("lol_down_k3", {clk_240m_tx_en, cdr_lock, phy_ready}, 6'd0);
    adv(240); chk("relock_pll_k243", pll_lock, 0);
    adv(1);   chk("relock_pll_k244", pll_lock, 1);
    adv(101); chk("relock_rdy_k345", phy_ready, 1);

    // cdr_rst on lane 2 only
    cdr_rst = 4'b0100;
    adv(1);   cdr_rst = 4'b0000; chk("cdrrst_lock_k", cdr_lock, 4'b1011);
    adv(1);   chk("cdrrst_rdy_k1", phy_ready, 0);
    adv(98);  chk("cdrrst_l2_k99", cdr_lock[2], 0);
    adv(1);   chk("cdrrst_l2_k100", cdr_lock[2], 1);
    adv(1);   chk("cdrrst_rdy_k101", phy_ready, 1);

    // One low synced sample at count 200 restarts the PLL count
    do_reset();
    phy_en = 1; lane_en = 4'hF; pll_lock_raw = 1; cdr_lock_raw = 4'hF;
    adv(202); pll_lock_raw = 0;
    adv(1);   pll_lock_raw = 1;
    adv(39);  chk("restart_pll_242", pll_lock, 0);
    adv(202); chk("restart_pll_444", pll_lock, 0);
    adv(1);   chk("restart_pll_445", pll_lock, 1);

    // Disabled lane with dead CDR does not block readiness
    do_reset();
    phy_en = 1; lane_en = 4'b0101; pll_lock_raw = 1; cdr_lock_raw = 4'b1101;
    adv(400);
    chk("partial_rdy", phy_ready, 1);
    chk("partial_rx", clk_240m_rx_en, 4'b0101);
    chk("partial_cdr", cdr_lock, 4'b0101);
    lane_en = 4'b0000;
    adv(1);   chk("nolanes_rdy", phy_ready, 0);

    // Loss-of-lock counter saturation on the short-count instance
    do_reset();
    f_phy_en = 1; f_lane_en = 1'b1; f_pll_raw = 1; f_cdr_raw = 1'b1;
    adv(10);  chk("fast_lock", f_pll_lock, 1);
    for (int e = 1; e <= 300; e++) begin
      f_pll_raw = 0; adv(1);
      f_pll_raw = 1; adv(8);
      if (e == 10) chk("fast_lol_10", f_lol_cnt, lol_exp(10));
    end
    chk("fast_lol_300", f_lol_cnt, lol_exp(300));
    f_pll_raw = 0; adv(1);
    f_pll_raw = 1; adv(1);
    f_lol_clr = 1; adv(1);
    f_lol_clr = 0; chk("fast_clr_with_event", f_lol_cnt, lol_exp(1));
    adv(8);
    f_lol_clr = 1; adv(1);
    f_lol_clr = 0; chk("fast_clr", f_lol_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
